// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the CPU MEM stage, the debug bridge, the data-memory arbiter and the memory array.
// The arbiter takes the slave view; requesters and memory together take the master view.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              cpu_err;

  logic              dbg_valid;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ready;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall, cpu_err,
    input  dbg_valid, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ready, dbg_rvalid, dbg_rdata,
    output mem_addr, mem_wdata, mem_wren,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall, cpu_err,
    output dbg_valid, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ready, dbg_rvalid, dbg_rdata,
    input  mem_addr, mem_wdata, mem_wren,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port data memory between the CPU load/store path and a debug/loader port,
// stalling the CPU while its load is in flight and forcing debug through after STARVE_MAX lost cycles.
module dmem_port_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 1536,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  dmem_port_arbiter_if.slave bus
);

  localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RD_CPU, RD_DBG} state_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < DEPTH_L;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  state_t            state;
  logic [CNT_W-1:0]  starve_cnt;
  logic [DATA_W-1:0] cpu_rdata_p1;
  logic [DATA_W-1:0] dbg_rdata_p1;
  logic              oor_vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] wdata_p1;

  logic              idle;
  logic              rd_cpu_done;
  logic              rd_dbg_done;
  logic              starved;
  logic              grant_dbg;
  logic              grant_cpu;
  logic              cpu_ok;
  logic              dbg_ok;
  logic              mem_hit;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              cpu_done;
  logic              dbg_oor_rd;

  // Stage p0: grant decision and memory request, all combinational in the request cycle.
  // Reset masks every grant and completion so an aborted access leaves no trace.
  assign idle        = (state == IDLE) && !rst;
  assign rd_cpu_done = (state == RD_CPU) && !rst;
  assign rd_dbg_done = (state == RD_DBG) && !rst;
  assign starved     = (starve_cnt == CNT_MAX);

  assign grant_dbg = idle && bus.dbg_valid && (!bus.cpu_req || starved);
  assign grant_cpu = idle && bus.cpu_req && !grant_dbg;

  assign cpu_ok  = in_range(bus.cpu_addr);
  assign dbg_ok  = in_range(bus.dbg_addr);
  assign mem_hit = (grant_cpu && cpu_ok) || (grant_dbg && dbg_ok);

  assign sel_we    = grant_dbg ? bus.dbg_we    : bus.cpu_we;
  assign sel_addr  = grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
  assign sel_wdata = grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;

  // Stores and out-of-range accesses finish in the grant cycle; loads finish in RD_CPU.
  assign cpu_done   = (grant_cpu && (bus.cpu_we || !cpu_ok)) || rd_cpu_done;
  assign dbg_oor_rd = grant_dbg && !dbg_ok && !bus.dbg_we;

  assign bus.cpu_stall = bus.cpu_req && !cpu_done;
  assign bus.cpu_err   = grant_cpu && !cpu_ok;
  assign bus.cpu_rdata = rd_cpu_done ? bus.mem_rdata : cpu_rdata_p1;

  assign bus.dbg_ready  = grant_dbg;
  assign bus.dbg_rvalid = rd_dbg_done || oor_vld_p1;
  assign bus.dbg_rdata  = rd_dbg_done ? bus.mem_rdata : dbg_rdata_p1;

  // Address/data hold their last granted value so the array never sees a floating bus.
  assign bus.mem_wren  = mem_hit && sel_we;
  assign bus.mem_addr  = mem_hit ? sel_addr  : addr_p1;
  assign bus.mem_wdata = mem_hit ? sel_wdata : wdata_p1;

  // Stage p1: FSM, starvation counter and captured read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      cpu_rdata_p1 <= '0;
      dbg_rdata_p1 <= '0;
      oor_vld_p1   <= 1'b0;
      addr_p1      <= '0;
      wdata_p1     <= '0;
    end else begin
      oor_vld_p1 <= dbg_oor_rd;

      if (rd_cpu_done) begin
        cpu_rdata_p1 <= bus.mem_rdata;
      end

      if (rd_dbg_done) begin
        dbg_rdata_p1 <= bus.mem_rdata;
      end else if (dbg_oor_rd) begin
        dbg_rdata_p1 <= '0;
      end

      if (mem_hit) begin
        addr_p1  <= sel_addr;
        wdata_p1 <= sel_wdata;
      end

      if (!bus.dbg_valid || grant_dbg) begin
        starve_cnt <= '0;
      end else begin
        starve_cnt <= sat_inc(starve_cnt);
      end

      unique case (state)
        IDLE: begin
          if (mem_hit && !sel_we) begin
            state <= grant_dbg ? RD_DBG : RD_CPU;
          end
        end
        RD_CPU:  state <= IDLE;
        RD_DBG:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
